// File: rtl/icache_axi_rd_bridge_if.sv
// Purpose: interfaces for the I-cache read port and the 32-bit AXI read channels.
// Latency: none; wiring only.
// Backpressure: the cache port uses rd_req/rd_rdy; AXI uses AR and R valid/ready.
//
// icache_rd_if : the cache is the master and the bridge is the slave.
//   rd_req/rd_type/rd_addr go from cache to bridge.
//   rd_rdy/ret_valid/ret_data go from bridge to cache.
// axi_rd_if    : the bridge is the master and the crossbar is the slave.
//   AR channel : arid/araddr/arlen/arsize/arburst/arvalid, with arready returned.
//   R channel  : rid/rdata/rresp/rlast/rvalid, with rready returned.

interface icache_rd_if;
  logic         rd_req;
  logic         rd_type;
  logic [31:0]  rd_addr;
  logic         rd_rdy;
  logic         ret_valid;
  logic [255:0] ret_data;

  modport master (output rd_req, rd_type, rd_addr,
                  input  rd_rdy, ret_valid, ret_data);
  modport slave  (input  rd_req, rd_type, rd_addr,
                  output rd_rdy, ret_valid, ret_data);
endinterface

interface axi_rd_if #(
  parameter int ID_W = 4
);
  logic [ID_W-1:0] arid;
  logic [31:0]     araddr;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;
  logic            arvalid;
  logic            arready;
  logic [ID_W-1:0] rid;
  logic [31:0]     rdata;
  logic [1:0]      rresp;
  logic            rlast;
  logic            rvalid;
  logic            rready;

  modport master (output arid, araddr, arlen, arsize, arburst, arvalid, rready,
                  input  arready, rid, rdata, rresp, rlast, rvalid);
  modport slave  (input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
                  output arready, rid, rdata, rresp, rlast, rvalid);
endinterface

// File: rtl/icache_axi_rd_bridge.sv
// Purpose: turns I-cache refill/uncached reads into single AXI read bursts and returns a 256-bit line.
// Latency: request accepted at edge N gives arvalid in N+1; last R beat at edge M gives ret_valid in M+1.
// Backpressure: rd_rdy only in IDLE; honours arready and rvalid; no back-pressure on the return pulse.
//
// Ports:
//   clk, resetn : clock and asynchronous active-low reset.
//   cache       : icache_rd_if.slave (rd_req/rd_type/rd_addr in; rd_rdy/ret_valid/ret_data out).
//   axi         : axi_rd_if.master (AR and R channels; rid and rresp are ignored).

module icache_axi_rd_bridge #(
  parameter int              ID_W   = 4,
  parameter logic [ID_W-1:0] AXI_ID = '0
) (
  input  logic         clk,
  input  logic         resetn,
  icache_rd_if.slave   cache,
  axi_rd_if.master     axi
);

  typedef enum logic [1:0] {IDLE, AR, R, RET} state_t;

  state_t             state_q, state_d;
  logic [2:0]         cnt_q,   cnt_d;
  logic [7:0][31:0]   buf_q,   buf_d;
  logic               type_q,  type_d;
  logic [31:0]        addr_q,  addr_d;

  // Only one transaction is ever outstanding, so the response ID and status carry no information.
  logic unused_ok;
  assign unused_ok = ^{axi.rid, axi.rresp};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      buf_q   <= '0;
      type_q  <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      type_q  <= type_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    type_d  = type_q;
    addr_d  = addr_q;

    unique case (state_q)
      IDLE: begin
        if (cache.rd_req) begin
          type_d  = cache.rd_type;
          addr_d  = cache.rd_addr;
          cnt_d   = '0;
          buf_d   = '0;
          state_d = AR;
        end
      end
      AR: begin
        if (axi.arready) state_d = R;
      end
      R: begin
        if (axi.rvalid) begin
          buf_d[cnt_q] = axi.rdata;
          // Counter sticks at 7 so an over-long burst keeps overwriting the top word.
          if (cnt_q != 3'd7) cnt_d = cnt_q + 3'd1;
          if (axi.rlast) state_d = RET;
        end
      end
      RET: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode straight from the registered state and latched request, so
  // araddr/arlen cannot move while AR is stalled.
  assign cache.rd_rdy    = (state_q == IDLE);
  assign cache.ret_valid = (state_q == RET);
  assign cache.ret_data  = buf_q;

  assign axi.arid    = AXI_ID;
  assign axi.araddr  = type_q ? {addr_q[31:5], 5'b0} : addr_q;
  assign axi.arlen   = type_q ? 8'd7 : 8'd0;
  assign axi.arsize  = 3'b010;
  assign axi.arburst = 2'b01;
  assign axi.arvalid = (state_q == AR);
  assign axi.rready  = (state_q == R);

endmodule

// File: tb/tb_icache_axi_rd_bridge.sv
// Purpose: directed self-checking bench for icache_axi_rd_bridge.
// Latency: drives and samples on the falling edge, half a cycle away from the active edge.
// Backpressure: exercises arready stalls and rvalid gaps.

module tb_icache_axi_rd_bridge;

  logic clk;
  logic resetn;

  icache_rd_if          cif ();
  axi_rd_if #(.ID_W(4)) aif ();

  icache_axi_rd_bridge #(.ID_W(4), .AXI_ID(4'd0)) dut (
    .clk    (clk),
    .resetn (resetn),
    .cache  (cif),
    .axi    (aif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Presents a request for one cycle; returns at the falling edge of the first AR cycle.
  task automatic req(input logic t, input logic [31:0] a);
    @(negedge clk);
    cif.rd_req  = 1'b1;
    cif.rd_type = t;
    cif.rd_addr = a;
    @(negedge clk);
    cif.rd_req  = 1'b0;
  endtask

  // Drives one R beat for one cycle; the bridge must be in R with rready high.
  task automatic beat(input logic [31:0] d, input logic last);
    aif.rvalid = 1'b1;
    aif.rdata  = d;
    aif.rlast  = last;
    @(negedge clk);
    aif.rvalid = 1'b0;
    aif.rlast  = 1'b0;
    aif.rdata  = '0;
  endtask

  logic [7:0][31:0] exp_line;

  initial begin
    resetn       = 1'b0;
    cif.rd_req   = 1'b0;
    cif.rd_type  = 1'b0;
    cif.rd_addr  = '0;
    aif.arready  = 1'b0;
    aif.rid      = '0;
    aif.rdata    = '0;
    aif.rresp    = '0;
    aif.rlast    = 1'b0;
    aif.rvalid   = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_rd_rdy",    cif.rd_rdy,    1);
    chk("rst_arvalid",   aif.arvalid,   0);
    chk("rst_rready",    aif.rready,    0);
    chk("rst_ret_valid", cif.ret_valid, 0);
    chk("rst_ret_data",  cif.ret_data,  0);
    resetn = 1'b1;

    // Line refill, AR accepted in the first AR cycle
    aif.arready = 1'b1;
    req(1'b1, 32'h1FC0_0024);
    chk("ref_arvalid", aif.arvalid, 1);
    chk("ref_araddr",  aif.araddr,  32'h1FC0_0020);
    chk("ref_arlen",   aif.arlen,   7);
    chk("ref_arsize",  aif.arsize,  3'b010);
    chk("ref_arburst", aif.arburst, 2'b01);
    chk("ref_arid",    aif.arid,    0);
    chk("ref_rd_rdy",  cif.rd_rdy,  0);
    @(negedge clk);
    chk("ref_rready",  aif.rready,  1);
    chk("ref_arv_off", aif.arvalid, 0);
    for (int k = 0; k < 8; k++) begin
      exp_line[k] = 32'h1111_1111 * (k + 1);
      beat(exp_line[k], k == 7);
    end
    chk("ref_ret_valid", cif.ret_valid, 1);
    chk("ref_ret_data",  cif.ret_data,  exp_line);
    chk("ref_word0",     cif.ret_data[31:0],    32'h1111_1111);
    chk("ref_word7",     cif.ret_data[255:224], 32'h8888_8888);
    @(negedge clk);
    chk("ref_ret_pulse", cif.ret_valid, 0);
    chk("ref_idle_rdy",  cif.rd_rdy,    1);

    // Uncached single-word read
    req(1'b0, 32'hBFAF_8004);
    chk("unc_araddr", aif.araddr, 32'hBFAF_8004);
    chk("unc_arlen",  aif.arlen,  0);
    @(negedge clk);
    beat(32'hDEAD_BEEF, 1'b1);
    chk("unc_ret_valid", cif.ret_valid, 1);
    chk("unc_ret_data",  cif.ret_data,  256'hDEAD_BEEF);
    @(negedge clk);
    chk("unc_ret_pulse", cif.ret_valid, 0);

    // AR stall with a second request held, then R beats with gaps
    aif.arready = 1'b0;
    req(1'b1, 32'h0000_1234);
    cif.rd_req  = 1'b1;
    cif.rd_type = 1'b0;
    cif.rd_addr = 32'h0000_5678;
    for (int c = 0; c < 5; c++) begin
      chk("stall_arvalid", aif.arvalid, 1);
      chk("stall_araddr",  aif.araddr,  32'h0000_1220);
      chk("stall_arlen",   aif.arlen,   7);
      chk("stall_rd_rdy",  cif.rd_rdy,  0);
      @(negedge clk);
    end
    aif.arready = 1'b1;
    @(negedge clk);
    cif.rd_req = 1'b0;
    chk("stall_rready", aif.rready, 1);
    chk("stall_araddr_keep", aif.araddr, 32'h0000_1220);
    for (int k = 0; k < 8; k++) begin
      exp_line[k] = 32'hA000_0000 + k;
      beat(exp_line[k], k == 7);
      if (k != 7) begin
        chk("gap_rready", aif.rready, 1);
        repeat (2) @(negedge clk);
      end
    end
    chk("gap_ret_valid", cif.ret_valid, 1);
    chk("gap_ret_data",  cif.ret_data,  exp_line);
    @(negedge clk);
    chk("gap_ret_pulse", cif.ret_valid, 0);
    chk("gap_arvalid",   aif.arvalid,   0);

    // Premature rlast on the third beat
    req(1'b1, 32'h0000_0040);
    @(negedge clk);
    exp_line = '0;
    for (int k = 0; k < 3; k++) begin
      exp_line[k] = 32'hC0DE_0000 + k;
      beat(exp_line[k], k == 2);
    end
    chk("pre_ret_valid", cif.ret_valid, 1);
    chk("pre_ret_data",  cif.ret_data,  exp_line);
    @(negedge clk);
    chk("pre_idle_rdy",  cif.rd_rdy,    1);

    // Over-long burst: the ninth beat overwrites word 7
    req(1'b1, 32'h0000_0080);
    @(negedge clk);
    for (int k = 0; k < 9; k++) begin
      if (k < 8) exp_line[k] = 32'h5000_0000 + k;
      else       exp_line[7] = 32'h5000_0000 + k;
      beat(32'h5000_0000 + k, k == 8);
    end
    chk("sat_ret_valid", cif.ret_valid, 1);
    chk("sat_ret_data",  cif.ret_data,  exp_line);
    @(negedge clk);

    // Reset in R after four beats, then a fresh transaction
    req(1'b1, 32'h0000_0100);
    @(negedge clk);
    for (int k = 0; k < 4; k++) beat(32'hEEEE_0000 + k, 1'b0);
    chk("mid_rready_pre", aif.rready, 1);
    resetn = 1'b0;
    #1;
    chk("mid_rready",    aif.rready,    0);
    chk("mid_rd_rdy",    cif.rd_rdy,    1);
    chk("mid_arvalid",   aif.arvalid,   0);
    chk("mid_ret_data",  cif.ret_data,  0);
    @(negedge clk);
    resetn = 1'b1;
    req(1'b1, 32'h0000_0200);
    chk("new_araddr", aif.araddr, 32'h0000_0200);
    @(negedge clk);
    beat(32'h1234_5678, 1'b1);
    chk("new_ret_valid", cif.ret_valid, 1);
    chk("new_ret_data",  cif.ret_data,  256'h1234_5678);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  // Guards against a stuck run.
  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/icache_axi_rd_bridge.md
Name: icache_axi_rd_bridge

Overview:
- Responder for the I-cache refill/uncached read interface (rd_req/rd_type/rd_addr/rd_rdy, ret_valid/ret_data).
- Converts each accepted request into one AXI3/AXI4 read transaction on a 32-bit AXI master port:
  - cache-line refill: 8-beat INCR burst;
  - uncached read: 1 beat.
- Assembles the returned beats into a 256-bit line and hands it back to the cache as a single-cycle ret_valid pulse.
- Sits between the I-cache and the AXI crossbar; one transaction outstanding at a time.

Parameters:
- AXI_ID, 4'd0, constant arid driven on every request.
- ID_W, 4, width of arid/rid.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- rd_req  in  1  cache read request.
- rd_type  in  1  1 = 32-byte cache line, 0 = single uncached word.
- rd_addr  in  32  request byte address.
- rd_rdy  out  1  bridge can accept a request this cycle.
- ret_valid  out  1  returned data valid (one-cycle pulse).
- ret_data  out  256  line data; word k in bits [32k+31:32k]; uncached word in [31:0].
- arid  out  ID_W  = AXI_ID.
- araddr  out  32  AXI read address.
- arlen  out  8  beats minus 1.
- arsize  out  3  constant 3'b010 (4 bytes).
- arburst  out  2  constant 2'b01 (INCR).
- arvalid  out  1  AR valid.
- arready  in  1  AR ready.
- rid  in  ID_W  ignored (single outstanding).
- rdata  in  32  read beat data.
- rresp  in  2  ignored; data is passed through regardless.
- rlast  in  1  last beat.
- rvalid  in  1  R valid.
- rready  out  1  R ready.

Behaviour:
- Reset: asynchronous, active-low. Forces state IDLE, beat counter 0, line buffer 0, latched type/address 0. Outputs: rd_rdy=1, arvalid=0, rready=0, ret_valid=0, ret_data=0.
- Reset mid-transaction abandons it; no AXI cleanup is attempted.
- FSM states: IDLE, AR, R, RET.
  - IDLE: rd_rdy=1. On rd_req=1, latch rd_type and rd_addr, clear beat counter and line buffer, go to AR.
  - AR: arvalid=1.
    - araddr = {addr[31:5],5'b0} when type=1, else addr.
    - arlen = 7 when type=1, else 0.
    - araddr/arlen are stable while arvalid=1 and arready=0.
    - On arready=1, go to R.
  - R: rready=1. Each cycle with rvalid=1:
    - write rdata into buffer word [cnt], then cnt++ (3 bits, saturates at 7; beats beyond the 8th overwrite word 7).
    - If rlast=1 on that beat, go to RET.
    - A premature rlast also ends the transaction; unfilled words stay 0.
  - RET: ret_valid=1 and ret_data=buffer for exactly one cycle, then IDLE. No back-pressure from the cache.
- rd_rdy=0 in AR, R and RET.
- Latency:
  - rd_req accepted at edge N → arvalid=1 in cycle N+1.
  - rlast beat accepted at edge M → ret_valid=1 in cycle M+1.
  - Next request can be accepted in cycle M+2.
- rd_req is ignored when rd_rdy=0; the requester holds it.
- Uncached reads: beat 0 lands in [31:0], upper 224 bits = 0.
- Simultaneous arready with entry into AR: the handshake completes in the first AR cycle (minimum one cycle in AR).
- Simultaneous rvalid and rlast on the first beat (uncached) → RET next cycle.

Test Plan:
- Line refill: rd_req=1, rd_type=1, rd_addr=0x1FC0_0024, arready=1 → araddr=0x1FC0_0020, arlen=7. Feed rdata 0x11111111..0x88888888 with rlast on beat 8 → one-cycle ret_valid, ret_data[31:0]=0x11111111, ret_data[255:224]=0x88888888.
- Uncached read: rd_type=0, rd_addr=0xBFAF_8004 → araddr=0xBFAF_8004, arlen=0. One beat 0xDEADBEEF with rlast → ret_data=0x…0_DEADBEEF (upper 224 bits 0).
- AR back-pressure: arready held 0 for 5 cycles → arvalid stays 1 with stable araddr/arlen. rd_rdy=0 throughout; a second rd_req is not accepted.
- R gaps: rvalid toggles 1,0,0,1… across 8 beats → words placed in order, no beat lost. ret_valid exactly 1 cycle.
- Premature rlast on beat 3 of a burst → RET next cycle, words 3..7 = 0, return to IDLE.
- Reset asserted in R after 4 beats → outputs reset immediately (rready=0, rd_rdy=1). A new request after release starts a fresh transaction with cnt=0.
